// File: rtl/rob_pkg.sv
// rob_pkg: shared constants, instruction-type codes and store-retire FSM
// encoding for the reorder-buffer tag controller.
package rob_pkg;

    localparam int unsigned ROB_DEPTH = 32;
    localparam int unsigned TAG_W     = 5;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned ITYPE_W   = 2;

    // Instruction-type codes as stored in the reorder buffer
    localparam logic [ITYPE_W-1:0] INST_ALU    = 2'h0;
    localparam logic [ITYPE_W-1:0] INST_LOAD   = 2'h1;
    localparam logic [ITYPE_W-1:0] INST_STORE  = 2'h2;
    localparam logic [ITYPE_W-1:0] INST_BRANCH = 2'h3;

    // Store-retire FSM encoding
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STORE_REQ = 2'd1,
        STORE_ACK = 2'd2
    } store_state_e;

endpackage

// File: rtl/rob_tag_ctrl_if.sv
// rob_tag_ctrl_if: bundles the dispatch, retire, store-commit and flush
// signals of the tag controller.
//   master : pipeline / buffer / store-buffer side (drives requests and acks)
//   slave  : the tag controller itself
interface rob_tag_ctrl_if
    import rob_pkg::*;
();
    logic                 flush_valid;
    logic                 dispatch_req;
    logic                 dispatch_stall;
    logic                 dispatch_valid;
    logic [TAG_W-1:0]     dispatch_rd_tag;
    logic                 retire_tag_ready;
    logic [TAG_W-1:0]     retire_tag;
    logic [ITYPE_W-1:0]   retire_inst_type;
    logic                 retire_acknowledge;
    logic                 retire_store_ack;
    logic                 store_commit_req;
    logic [TAG_W-1:0]     store_commit_tag;
    logic                 store_commit_done;
    logic [CNT_W-1:0]     rob_count;

    modport master (
        output flush_valid, dispatch_req, retire_inst_type,
               retire_acknowledge, store_commit_done,
        input  dispatch_stall, dispatch_valid, dispatch_rd_tag,
               retire_tag_ready, retire_tag, retire_store_ack,
               store_commit_req, store_commit_tag, rob_count
    );

    modport slave (
        input  flush_valid, dispatch_req, retire_inst_type,
               retire_acknowledge, store_commit_done,
        output dispatch_stall, dispatch_valid, dispatch_rd_tag,
               retire_tag_ready, retire_tag, retire_store_ack,
               store_commit_req, store_commit_tag, rob_count
    );

endinterface

// File: rtl/rob_wrap_ptr.sv
// rob_wrap_ptr: 5-bit circular pointer; clear has priority over increment,
// and the increment wraps 31 -> 0 by natural overflow.
//   clock, nreset : clock, async active-low reset
//   i_clr         : synchronous clear to 0
//   i_inc         : advance by one
//   o_ptr         : current pointer value
module rob_wrap_ptr
    import rob_pkg::*;
(
    input  logic             clock,
    input  logic             nreset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [TAG_W-1:0] o_ptr
);

    logic [TAG_W-1:0] r_ptr;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + TAG_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_tag_ctrl.sv
// rob_tag_ctrl: allocates destination tags at dispatch, tracks the oldest
// in-flight tag for retirement and sequences store commits with the store
// buffer before the head store entry is released.
//   clock, nreset : clock, async active-low reset
//   bus (slave)   : dispatch / retire / store-commit / flush handshakes
module rob_tag_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned          DEPTH      = ROB_DEPTH,
    parameter logic [ITYPE_W-1:0]   INST_STORE = rob_pkg::INST_STORE
)(
    input  logic            clock,
    input  logic            nreset,
    rob_tag_ctrl_if.slave   bus
);

    logic [TAG_W-1:0] w_head;
    logic [TAG_W-1:0] w_tail;
    logic [CNT_W-1:0] r_count;
    store_state_e     r_state;
    store_state_e     w_state_nxt;

    logic w_full;
    logic w_empty;
    logic w_dispatch_valid;
    logic w_retire_ready;
    logic w_store_ack;
    logic w_retire;

    // Occupancy decodes from registered count only, so a retire while full
    // frees the slot for dispatch one cycle later.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    assign w_dispatch_valid = bus.dispatch_req && !w_full && !bus.flush_valid;
    assign w_retire_ready   = !w_empty && (r_state == IDLE);
    assign w_store_ack      = (r_state == STORE_ACK);
    assign w_retire         = (bus.retire_acknowledge && w_retire_ready) || w_store_ack;

    // Head and tail pointers; flush clears both
    rob_wrap_ptr u_head_ptr (
        .clock  (clock),
        .nreset (nreset),
        .i_clr  (bus.flush_valid),
        .i_inc  (w_retire),
        .o_ptr  (w_head)
    );

    rob_wrap_ptr u_tail_ptr (
        .clock  (clock),
        .nreset (nreset),
        .i_clr  (bus.flush_valid),
        .i_inc  (w_dispatch_valid),
        .o_ptr  (w_tail)
    );

    // Occupancy counter; simultaneous dispatch and retire cancel out
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_count <= '0;
        end else if (bus.flush_valid) begin
            r_count <= '0;
        end else if (w_dispatch_valid && !w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end else if (!w_dispatch_valid && w_retire) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Store-retire FSM state register
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Store-retire FSM next state; flush abandons any commit in progress
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush_valid) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty && (bus.retire_inst_type == INST_STORE)) begin
                        w_state_nxt = STORE_REQ;
                    end
                end
                STORE_REQ: begin
                    if (bus.store_commit_done) begin
                        w_state_nxt = STORE_ACK;
                    end
                end
                STORE_ACK: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.dispatch_stall   = w_full;
    assign bus.dispatch_valid   = w_dispatch_valid;
    assign bus.dispatch_rd_tag  = w_tail;
    assign bus.retire_tag_ready = w_retire_ready;
    assign bus.retire_tag       = w_head;
    assign bus.retire_store_ack = w_store_ack;
    assign bus.store_commit_req = (r_state == STORE_REQ);
    assign bus.store_commit_tag = w_head;
    assign bus.rob_count        = r_count;

endmodule

// File: tb/tb_rob_tag_ctrl.sv
// tb_rob_tag_ctrl: directed bench for rob_tag_ctrl with a tag scoreboard.
module tb_rob_tag_ctrl;
    import rob_pkg::*;

    logic clock = 1'b0;
    logic nreset;

    rob_tag_ctrl_if u_if ();

    rob_tag_ctrl #(
        .DEPTH      (32),
        .INST_STORE (2'h2)
    ) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (u_if.slave)
    );

    always #5 clock = ~clock;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [4:0] q_tags[$];
    logic [4:0] m_tail;
    logic [4:0] t_exp;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Dispatch n tags back to back; each allocated tag is queued for retire
    task automatic dispatch_n(input int n);
        for (int i = 0; i < n; i++) begin
            u_if.dispatch_req = 1'b1;
            #1;
            chk("dispatch_valid", 32'(u_if.dispatch_valid), 32'd1);
            chk("dispatch_rd_tag", 32'(u_if.dispatch_rd_tag), 32'(m_tail));
            q_tags.push_back(m_tail);
            m_tail = m_tail + 5'd1;
            next_cycle();
        end
        u_if.dispatch_req = 1'b0;
    endtask

    // Retire n non-store entries, each compared against the scoreboard
    task automatic retire_n(input int n);
        for (int i = 0; i < n; i++) begin
            u_if.retire_acknowledge = 1'b1;
            #1;
            t_exp = q_tags.pop_front();
            chk("retire_tag", 32'(u_if.retire_tag), 32'(t_exp));
            chk("retire_tag_ready", 32'(u_if.retire_tag_ready), 32'd1);
            next_cycle();
        end
        u_if.retire_acknowledge = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string ph);
        chk({ph, "_dispatch_stall"},   32'(u_if.dispatch_stall),   32'd0);
        chk({ph, "_retire_tag_ready"}, 32'(u_if.retire_tag_ready), 32'd0);
        chk({ph, "_retire_store_ack"}, 32'(u_if.retire_store_ack), 32'd0);
        chk({ph, "_store_commit_req"}, 32'(u_if.store_commit_req), 32'd0);
        chk({ph, "_dispatch_rd_tag"},  32'(u_if.dispatch_rd_tag),  32'd0);
        chk({ph, "_retire_tag"},       32'(u_if.retire_tag),       32'd0);
        chk({ph, "_rob_count"},        32'(u_if.rob_count),        32'd0);
    endtask

    initial begin
        u_if.flush_valid        = 1'b0;
        u_if.dispatch_req       = 1'b0;
        u_if.retire_inst_type   = INST_ALU;
        u_if.retire_acknowledge = 1'b0;
        u_if.store_commit_done  = 1'b0;
        m_tail = 5'd0;
        nreset = 1'b1;
        #2 nreset = 1'b0;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk_reset_outputs("rst");
        nreset = 1'b1;
        next_cycle();
        chk("post_rst_count", 32'(u_if.rob_count), 32'd0);

        // Fill: tags 0..31, then full and stalled
        dispatch_n(32);
        chk("full_stall", 32'(u_if.dispatch_stall), 32'd1);
        chk("full_count", 32'(u_if.rob_count), 32'd32);
        u_if.dispatch_req = 1'b1;
        #1;
        chk("req33_valid", 32'(u_if.dispatch_valid), 32'd0);

        // Retire while full: freed slot usable one cycle later, tag wraps to 0
        u_if.retire_acknowledge = 1'b1;
        #1;
        chk("full_retire_valid", 32'(u_if.dispatch_valid), 32'd0);
        t_exp = q_tags.pop_front();
        chk("full_retire_tag", 32'(u_if.retire_tag), 32'(t_exp));
        next_cycle();
        u_if.retire_acknowledge = 1'b0;
        #1;
        chk("after_retire_count", 32'(u_if.rob_count), 32'd31);
        chk("after_retire_stall", 32'(u_if.dispatch_stall), 32'd0);
        chk("wrap_valid", 32'(u_if.dispatch_valid), 32'd1);
        chk("wrap_tag", 32'(u_if.dispatch_rd_tag), 32'd0);
        q_tags.push_back(m_tail);
        m_tail = m_tail + 5'd1;
        next_cycle();
        u_if.dispatch_req = 1'b0;
        chk("refull_count", 32'(u_if.rob_count), 32'd32);

        // Drain to 5 entries, then dispatch and retire together
        retire_n(27);
        chk("drain_count", 32'(u_if.rob_count), 32'd5);
        chk("drain_head", 32'(u_if.retire_tag), 32'd28);
        u_if.dispatch_req       = 1'b1;
        u_if.retire_acknowledge = 1'b1;
        #1;
        chk("both_valid", 32'(u_if.dispatch_valid), 32'd1);
        t_exp = q_tags.pop_front();
        chk("both_retire_tag", 32'(u_if.retire_tag), 32'(t_exp));
        chk("both_disp_tag", 32'(u_if.dispatch_rd_tag), 32'(m_tail));
        q_tags.push_back(m_tail);
        m_tail = m_tail + 5'd1;
        next_cycle();
        u_if.dispatch_req       = 1'b0;
        u_if.retire_acknowledge = 1'b0;
        chk("both_count", 32'(u_if.rob_count), 32'd5);
        chk("both_head", 32'(u_if.retire_tag), 32'd29);
        chk("both_tail", 32'(u_if.dispatch_rd_tag), 32'd2);

        // Flush beats a concurrent dispatch
        u_if.flush_valid  = 1'b1;
        u_if.dispatch_req = 1'b1;
        #1;
        chk("flush_disp_valid", 32'(u_if.dispatch_valid), 32'd0);
        next_cycle();
        u_if.flush_valid  = 1'b0;
        u_if.dispatch_req = 1'b0;
        chk("flush_count", 32'(u_if.rob_count), 32'd0);
        chk("flush_tail", 32'(u_if.dispatch_rd_tag), 32'd0);
        chk("flush_head", 32'(u_if.retire_tag), 32'd0);
        chk("flush_ready", 32'(u_if.retire_tag_ready), 32'd0);
        q_tags.delete();
        m_tail = 5'd0;

        // Bring a store to the head at tag 3 with 9 entries in flight
        dispatch_n(12);
        retire_n(3);
        chk("pre_store_count", 32'(u_if.rob_count), 32'd9);
        chk("pre_store_head", 32'(u_if.retire_tag), 32'd3);

        // store_commit_done in IDLE has no effect
        u_if.store_commit_done = 1'b1;
        next_cycle();
        u_if.store_commit_done = 1'b0;
        #1;
        chk("stray_done_ack", 32'(u_if.retire_store_ack), 32'd0);
        chk("stray_done_req", 32'(u_if.store_commit_req), 32'd0);
        chk("stray_done_count", 32'(u_if.rob_count), 32'd9);

        u_if.retire_inst_type = INST_STORE;
        #1;
        chk("store_idle_ready", 32'(u_if.retire_tag_ready), 32'd1);
        next_cycle();
        // retire_acknowledge during the commit must be ignored
        u_if.retire_acknowledge = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("commit_req", 32'(u_if.store_commit_req), 32'd1);
            chk("commit_tag", 32'(u_if.store_commit_tag), 32'd3);
            chk("commit_ready", 32'(u_if.retire_tag_ready), 32'd0);
            chk("commit_count", 32'(u_if.rob_count), 32'd9);
            next_cycle();
        end
        u_if.retire_acknowledge = 1'b0;
        u_if.store_commit_done  = 1'b1;
        #1;
        chk("done_cycle_req", 32'(u_if.store_commit_req), 32'd1);
        next_cycle();
        u_if.store_commit_done = 1'b0;
        u_if.retire_inst_type  = INST_ALU;
        #1;
        chk("store_ack", 32'(u_if.retire_store_ack), 32'd1);
        chk("store_ack_req", 32'(u_if.store_commit_req), 32'd0);
        chk("store_ack_ready", 32'(u_if.retire_tag_ready), 32'd0);
        t_exp = q_tags.pop_front();
        chk("store_ack_tag", 32'(u_if.retire_tag), 32'(t_exp));
        next_cycle();
        chk("store_ack_pulse", 32'(u_if.retire_store_ack), 32'd0);
        chk("store_head", 32'(u_if.retire_tag), 32'd4);
        chk("store_count", 32'(u_if.rob_count), 32'd8);
        chk("store_idle", 32'(u_if.retire_tag_ready), 32'd1);

        // Flush during STORE_REQ with 10 entries
        dispatch_n(2);
        u_if.retire_inst_type = INST_STORE;
        next_cycle();
        chk("f_store_req", 32'(u_if.store_commit_req), 32'd1);
        chk("f_store_tag", 32'(u_if.store_commit_tag), 32'd4);
        chk("f_store_count", 32'(u_if.rob_count), 32'd10);
        u_if.flush_valid = 1'b1;
        next_cycle();
        u_if.flush_valid      = 1'b0;
        u_if.retire_inst_type = INST_ALU;
        chk("fs_count", 32'(u_if.rob_count), 32'd0);
        chk("fs_head", 32'(u_if.retire_tag), 32'd0);
        chk("fs_tail", 32'(u_if.dispatch_rd_tag), 32'd0);
        chk("fs_req", 32'(u_if.store_commit_req), 32'd0);
        chk("fs_ready", 32'(u_if.retire_tag_ready), 32'd0);
        chk("fs_ack", 32'(u_if.retire_store_ack), 32'd0);
        q_tags.delete();
        m_tail = 5'd0;

        // Asynchronous reset between edges at count 7
        dispatch_n(7);
        chk("pre_async_count", 32'(u_if.rob_count), 32'd7);
        #2 nreset = 1'b0;
        #1;
        chk_reset_outputs("arst");
        #2 nreset = 1'b1;
        q_tags.delete();
        m_tail = 5'd0;
        next_cycle();
        u_if.dispatch_req = 1'b1;
        #1;
        chk("post_arst_valid", 32'(u_if.dispatch_valid), 32'd1);
        chk("post_arst_tag", 32'(u_if.dispatch_rd_tag), 32'd0);
        next_cycle();
        u_if.dispatch_req = 1'b0;
        chk("post_arst_count", 32'(u_if.rob_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rob_tag_ctrl.md
ROB_TAG_CTRL -- requirements
Module: rob_tag_ctrl

Interface
REQ-001 Parameter: DEPTH, 32, number of reorder-buffer entries; tag width is fixed at 5 bits.
REQ-002 Parameter: INST_STORE, 2'h2, instruction-type code for stores.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 flush_valid  input  1  pipeline flush; discards all in-flight tags.
REQ-006 dispatch_req  input  1  dispatch stage requests a new destination tag.
REQ-007 dispatch_stall  output  1  no tag available this cycle (buffer full).
REQ-008 dispatch_valid  output  1  allocation accepted this cycle; drives the buffer's write enable.
REQ-009 dispatch_rd_tag  output  5  tag allocated (tail pointer).
REQ-010 retire_tag_ready  output  1  head tag is valid for retirement (buffer not empty).
REQ-011 retire_tag  output  5  oldest in-flight tag (head pointer).
REQ-012 retire_inst_type  input  2  instruction type read from the buffer at retire_tag.
REQ-013 retire_acknowledge  input  1  buffer reports that the head non-store entry retired this cycle.
REQ-014 retire_store_ack  output  1  one-cycle pulse; head store is committed and its entry is cleared.
REQ-015 store_commit_req  output  1  request to the store buffer to commit the head store.
REQ-016 store_commit_tag  output  5  tag of the store being committed.
REQ-017 store_commit_done  input  1  store buffer has completed the commit (single-cycle pulse).
REQ-018 rob_count  output  6  number of occupied entries, range 0..32.

Function
REQ-019 Pointers: head and tail are 5 bits and wrap from 31 to 0; count is 6 bits.
REQ-020 full = (count == 32), empty = (count == 0), both decoded from registered state.
REQ-021 dispatch_stall = full; dispatch_valid = dispatch_req && !full && !flush_valid (combinational).
REQ-022 dispatch_rd_tag = tail; on dispatch_valid, tail advances by 1 at the next edge.
REQ-023 retire_tag = head; retire_tag_ready = !empty && (state == IDLE).
REQ-024 Retire event = (retire_acknowledge && retire_tag_ready) || retire_store_ack; on a retire event, head advances by 1.
REQ-025 Count update: +1 on dispatch only; -1 on retire only; unchanged when both occur in the same cycle.
REQ-026 When full and a retire occurs, dispatch remains stalled in that cycle; the freed slot becomes usable one cycle later.
REQ-027 Store FSM states: IDLE, STORE_REQ, STORE_ACK.
REQ-028 IDLE -> STORE_REQ when !empty && retire_inst_type == INST_STORE; head does not advance.
REQ-029 STORE_REQ: store_commit_req = 1 and store_commit_tag = head, held stable until store_commit_done; then -> STORE_ACK.
REQ-030 STORE_ACK: retire_store_ack = 1 for exactly one cycle, head advances, state returns to IDLE.
REQ-031 Minimum store retire latency is 3 cycles from the store reaching the head to the next retire_tag_ready.
REQ-032 retire_acknowledge received outside IDLE is ignored.
REQ-033 flush_valid has priority over all other events: at the next edge head, tail and count become 0, the FSM returns to IDLE, and store_commit_req deasserts; a commit in progress is abandoned.
REQ-034 store_commit_done received outside STORE_REQ is ignored.

Reset
REQ-035 While nreset is low: head = 0, tail = 0, count = 0, state = IDLE.
REQ-036 Output values during reset: dispatch_stall = 0, retire_tag_ready = 0, retire_store_ack = 0, store_commit_req = 0, dispatch_rd_tag = 0, retire_tag = 0, rob_count = 0.
REQ-037 Reset asserted mid-operation (including during STORE_REQ) shall take effect immediately, without waiting for a clock edge.

Structure
REQ-038 Shared package rob_pkg shall hold ROB_DEPTH, TAG_W, the instruction-type codes (including INST_STORE = 2'h2) and the store FSM state encoding.
REQ-039 One sub-module is natural: rob_wrap_ptr (5-bit wrapping pointer with increment and clear), instantiated once for head and once for tail.

Verification
REQ-040 After reset, 32 consecutive dispatch_req cycles -> tags 0..31 issued, then dispatch_stall = 1 and rob_count = 32; a 33rd request gives dispatch_valid = 0.
REQ-041 When full, retire_acknowledge on tag 0 with dispatch_req held -> that cycle dispatch_valid = 0; next cycle dispatch_valid = 1 with tag 0 (wrap), count = 32.
REQ-042 Simultaneous dispatch and retire at count = 5 -> count stays 5, head and tail each advance by 1.
REQ-043 Store at head (tag 3): store_commit_req with tag 3; store_commit_done 4 cycles later -> one-cycle retire_store_ack, head = 4, FSM back in IDLE.
REQ-044 flush_valid during STORE_REQ with count = 10 -> next cycle count = 0, head = tail = 0, store_commit_req = 0, retire_tag_ready = 0.
REQ-045 nreset pulsed low between clock edges at count = 7 -> all outputs take their reset values immediately; the first dispatch after release receives tag 0.
